// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution, illegal-control flag and taken-branch counter
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              bne_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic [DATA_W-1:0] branch_target_in,
  input  logic [4:0]        rd_in,
  output logic              valid_out,
  output logic              Branch_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              bne_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [DATA_W-1:0] branch_target_out,
  output logic [4:0]        rd_out,
  output logic              PCSrc,
  output logic              ctrl_err,
  output logic [CNT_W-1:0]  taken_cnt
);
  assign PCSrc = valid_out & Branch_out & (bne_out ? ~zero_out : zero_out);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_out         <= 1'b0;
      Branch_out        <= 1'b0;
      MemRead_out       <= 1'b0;
      MemWrite_out      <= 1'b0;
      bne_out           <= 1'b0;
      RegWrite_out      <= 1'b0;
      MemtoReg_out      <= 1'b0;
      zero_out          <= 1'b0;
      alu_result_out    <= '0;
      write_data_out    <= '0;
      branch_target_out <= '0;
      rd_out            <= '0;
      ctrl_err          <= 1'b0;
      taken_cnt         <= '0;
    end else begin
      if (flush) begin
        valid_out         <= 1'b0;
        Branch_out        <= 1'b0;
        MemRead_out       <= 1'b0;
        MemWrite_out      <= 1'b0;
        bne_out           <= 1'b0;
        RegWrite_out      <= 1'b0;
        MemtoReg_out      <= 1'b0;
        zero_out          <= 1'b0;
        alu_result_out    <= '0;
        write_data_out    <= '0;
        branch_target_out <= '0;
        rd_out            <= '0;
      end else if (!stall) begin
        valid_out         <= valid_in;
        Branch_out        <= valid_in & Branch_in;
        MemRead_out       <= valid_in & MemRead_in;
        // a simultaneous read+write keeps the read and drops the write
        MemWrite_out      <= valid_in & MemWrite_in & ~MemRead_in;
        bne_out           <= valid_in & bne_in;
        RegWrite_out      <= valid_in & RegWrite_in;
        MemtoReg_out      <= valid_in & MemtoReg_in;
        zero_out          <= zero_in;
        alu_result_out    <= alu_result_in;
        write_data_out    <= write_data_in;
        branch_target_out <= branch_target_in;
        rd_out            <= rd_in;
        ctrl_err          <= ctrl_err | (valid_in & MemRead_in & MemWrite_in);
      end
      if (PCSrc && !stall && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed and random checks of ex_mem_reg against a behavioural model
module tb_ex_mem_reg;
  typedef struct packed {
    logic        v, br, mr, mw, bne, rw, m2r, z;
    logic [31:0] alu, wd, bt;
    logic [4:0]  rd;
    logic        err;
    logic [15:0] cnt;
  } st_t;
  logic clk = 0, rst_n = 0, stall, flush, valid_in, Branch_in, MemRead_in, MemWrite_in, bne_in;
  logic RegWrite_in, MemtoReg_in, zero_in;
  logic [31:0] alu_result_in, write_data_in, branch_target_in;
  logic [4:0] rd_in;
  logic valid_out, Branch_out, MemRead_out, MemWrite_out, bne_out, RegWrite_out, MemtoReg_out, zero_out;
  logic [31:0] alu_result_out, write_data_out, branch_target_out;
  logic [4:0] rd_out;
  logic PCSrc, ctrl_err;
  logic [15:0] taken_cnt;
  st_t m, obs;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .bne_in(bne_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .branch_target_in(branch_target_in),
    .rd_in(rd_in), .valid_out(valid_out), .Branch_out(Branch_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .bne_out(bne_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .zero_out(zero_out), .alu_result_out(alu_result_out),
    .write_data_out(write_data_out), .branch_target_out(branch_target_out), .rd_out(rd_out),
    .PCSrc(PCSrc), .ctrl_err(ctrl_err), .taken_cnt(taken_cnt)
  );
  assign obs = {valid_out, Branch_out, MemRead_out, MemWrite_out, bne_out, RegWrite_out, MemtoReg_out,
                zero_out, alu_result_out, write_data_out, branch_target_out, rd_out, ctrl_err, taken_cnt};
  function automatic logic taken(st_t s);
    return s.v && s.br && (s.bne ? !s.z : s.z);
  endfunction
  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic clr();
    {stall, flush, valid_in, Branch_in, MemRead_in, MemWrite_in, bne_in, RegWrite_in, MemtoReg_in, zero_in} = '0;
    {alu_result_in, write_data_in, branch_target_in, rd_in} = '0;
  endtask
  task automatic step(string tag);
    st_t n = m;
    if (flush) begin
      n = '0;
      n.err = m.err;
      n.cnt = m.cnt;
    end else if (!stall) begin
      n.v = valid_in;
      {n.br, n.mr, n.bne, n.rw, n.m2r} = valid_in ? {Branch_in, MemRead_in, bne_in, RegWrite_in, MemtoReg_in} : 5'b0;
      n.mw = valid_in && MemWrite_in && !MemRead_in;
      {n.z, n.alu, n.wd, n.bt, n.rd} = {zero_in, alu_result_in, write_data_in, branch_target_in, rd_in};
      if (valid_in && MemRead_in && MemWrite_in) n.err = 1'b1;
    end
    if (taken(m) && !stall) n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
    @(posedge clk);
    m = n;
    #1;
    chk({tag, ".state"}, 128'(obs), 128'(m));
    chk({tag, ".pcsrc"}, 128'(PCSrc), 128'(taken(m)));
  endtask
  task automatic rst_pulse(string tag);
    #2 rst_n = 0;
    #1 m = '0;
    chk({tag, ".rst_state"}, 128'(obs), 128'(0));
    chk({tag, ".rst_pcsrc"}, 128'(PCSrc), 128'(0));
    #1 rst_n = 1;
  endtask
  initial begin
    clr();
    m = '0;
    #12;
    chk("reset.state", 128'(obs), 128'(0));
    chk("reset.pcsrc", 128'(PCSrc), 128'(0));
    rst_n = 1;
    valid_in = 1; MemWrite_in = 1; alu_result_in = 32'h40; write_data_in = 32'hDEADBEEF;
    step("sw");
    chk("sw.memwrite", 128'(MemWrite_out), 128'(1));
    chk("sw.alu", 128'(alu_result_out), 128'(32'h40));
    chk("sw.wdata", 128'(write_data_out), 128'(32'hDEADBEEF));
    chk("sw.pcsrc0", 128'(PCSrc), 128'(0));
    clr(); valid_in = 1; Branch_in = 1; zero_in = 1; branch_target_in = 32'h100;
    step("beq");
    chk("beq.pcsrc1", 128'(PCSrc), 128'(1));
    chk("beq.target", 128'(branch_target_out), 128'(32'h100));
    chk("beq.cnt0", 128'(taken_cnt), 128'(0));
    clr();
    step("nop_after_beq");
    chk("beq.cnt1", 128'(taken_cnt), 128'(1));
    valid_in = 1; Branch_in = 1; bne_in = 1; zero_in = 1;
    step("bne_z1");
    chk("bne.pcsrc0", 128'(PCSrc), 128'(0));
    clr(); valid_in = 1; bne_in = 1;
    step("bne_nobranch");
    chk("bne_nobr.pcsrc0", 128'(PCSrc), 128'(0));
    clr(); valid_in = 1; Branch_in = 1; zero_in = 1; branch_target_in = 32'h200; rd_in = 5'd7;
    step("stall_beq");
    clr(); stall = 1; alu_result_in = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      step("stalled");
      chk("stall.pcsrc", 128'(PCSrc), 128'(1));
      chk("stall.cnt", 128'(taken_cnt), 128'(1));
    end
    stall = 0;
    step("stall_release");
    chk("stall.cnt_once", 128'(taken_cnt), 128'(2));
    clr(); valid_in = 1; MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1;
    alu_result_in = 32'h55; write_data_in = 32'h66; branch_target_in = 32'h77; rd_in = 5'd9; zero_in = 1;
    stall = 1; flush = 1;
    step("stall_flush_lw");
    chk("flush.valid", 128'(valid_out), 128'(0));
    chk("flush.memread", 128'(MemRead_out), 128'(0));
    chk("flush.data", 128'({alu_result_out, write_data_out, branch_target_out}), 128'(0));
    clr(); valid_in = 1; MemRead_in = 1; MemWrite_in = 1;
    step("illegal");
    chk("illegal.mr_mw", 128'({MemRead_out, MemWrite_out}), 128'(2'b10));
    chk("illegal.err", 128'(ctrl_err), 128'(1));
    for (int i = 0; i < 10; i++) begin
      clr(); valid_in = 1; RegWrite_in = 1; alu_result_in = $urandom; rd_in = 5'($urandom);
      step("clean_load");
      chk("err.sticky", 128'(ctrl_err), 128'(1));
    end
    stall = 1;
    rst_pulse("rst_mid_stall");
    chk("err.cleared", 128'(ctrl_err), 128'(0));
    step("post_rst_stall");
    for (int i = 0; i < 400; i++) begin
      {valid_in, Branch_in, MemRead_in, MemWrite_in, bne_in, RegWrite_in, MemtoReg_in, zero_in} = 8'($urandom);
      alu_result_in = $urandom; write_data_in = $urandom; branch_target_in = $urandom; rd_in = 5'($urandom);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      if (i == 200) begin
        flush = 1;
        rst_pulse("rst_mid_flush");
      end
      step("random");
    end
    clr(); valid_in = 1; Branch_in = 1; zero_in = 1;
    for (int i = 0; i < 70000 && m.cnt != 16'hFFFE; i++) step("preload");
    chk("sat.fffe", 128'(taken_cnt), 128'(16'hFFFE));
    step("sat1");
    step("sat2");
    chk("sat.ffff", 128'(taken_cnt), 128'(16'hFFFF));
    for (int i = 0; i < 3; i++) step("sat_hold");
    chk("sat.hold", 128'(taken_cnt), 128'(16'hFFFF));
    rst_pulse("rst_async");
    step("post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result, store data and branch target.
REQ-002 Parameter CNT_W, default 16, width of the taken-branch counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hold all registered state this cycle.
REQ-006 flush  input  1  load a bubble this cycle.
REQ-007 valid_in  input  1  EX stage holds a real instruction.
REQ-008 Branch_in, MemRead_in, MemWrite_in, bne_in, RegWrite_in, MemtoReg_in  input  1 each  EX-stage control bits.
REQ-009 zero_in  input  1  ALU zero flag.
REQ-010 alu_result_in, write_data_in, branch_target_in  input  DATA_W each  EX-stage datapath values.
REQ-011 rd_in  input  5  destination register.
REQ-012 valid_out, Branch_out, MemRead_out, MemWrite_out, bne_out, RegWrite_out, MemtoReg_out, zero_out  output  1 each  registered copies.
REQ-013 alu_result_out, write_data_out, branch_target_out  output  DATA_W each  registered copies.
REQ-014 rd_out  output  5  registered destination register.
REQ-015 PCSrc  output  1  branch taken in MEM stage; also the flush request to IF/ID and ID/EX.
REQ-016 ctrl_err  output  1  sticky illegal-control flag.
REQ-017 taken_cnt  output  CNT_W  saturating count of taken branches.

Function
REQ-018 Update priority per rising edge SHALL be: flush > stall > normal load.
REQ-019 Normal load (flush=0, stall=0) SHALL capture every *_in into its *_out with one-cycle latency.
REQ-020 Load with valid_in=0 SHALL clear valid_out and all six control outputs; datapath fields, zero_out and rd_out still capture.
REQ-021 Flush=1 SHALL clear valid_out, all control outputs, zero_out, rd_out and all datapath outputs to 0, regardless of stall.
REQ-022 Stall=1 with flush=0 SHALL hold every registered output, ctrl_err and taken_cnt unchanged.
REQ-023 Load with valid_in=1, MemRead_in=1 and MemWrite_in=1 SHALL register MemRead_out=1, MemWrite_out=0, and set ctrl_err=1.
REQ-024 ctrl_err SHALL remain 1 until reset; no other event clears it.
REQ-025 PCSrc SHALL be combinational from registered state only: valid_out AND Branch_out AND (bne_out ? NOT zero_out : zero_out).
REQ-026 bne_out=1 with Branch_out=0 SHALL yield PCSrc=0.
REQ-027 taken_cnt SHALL increment by 1 on each rising edge where PCSrc=1 and stall=0, including when flush=1 that edge.
REQ-028 taken_cnt SHALL saturate at all-ones and not wrap.
REQ-029 A stalled taken branch SHALL keep PCSrc=1 for every stalled cycle and be counted exactly once.
REQ-030 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, clear every output register, ctrl_err and taken_cnt to 0, giving PCSrc=0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion performs a normal load/stall/flush per REQ-018.

Verification
REQ-033 Load valid sw (MemWrite_in=1, alu_result_in=0x00000040, write_data_in=0xDEADBEEF, rd_in=0) -> next cycle MemWrite_out=1, alu_result_out=0x40, write_data_out=0xDEADBEEF, PCSrc=0.
REQ-034 Load valid beq Branch_in=1, zero_in=1, branch_target_in=0x100 -> PCSrc=1, branch_target_out=0x100, taken_cnt 0->1 on the following unstalled edge; same with bne_in=1, zero_in=1 -> PCSrc=0.
REQ-035 Taken branch registered, then stall=1 for 3 cycles -> outputs frozen, PCSrc=1 throughout, taken_cnt incremented exactly once after stall drops.
REQ-036 stall=1 and flush=1 together on a valid lw -> next cycle valid_out=0, MemRead_out=0, all datapath outputs 0.
REQ-037 Valid load with MemRead_in=MemWrite_in=1 -> MemRead_out=1, MemWrite_out=0, ctrl_err=1; ctrl_err stays 1 through 10 further clean loads, clears only on rst_n=0.
REQ-038 Preload taken_cnt to 0xFFFE via taken branches, two more unstalled taken cycles -> 0xFFFF, then holds 0xFFFF; rst_n pulsed low between clock edges -> all outputs 0 before next edge.
